// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron fixed-point multiply-accumulate with saturating sum and bias.
// Ports: clk/rst (sync, active-high); myinput/myinputValid/myinputReady sample stream;
//        weight_ren/weight_radd/weight_rdata weight-memory read port (rdata one cycle after ren);
//        bias sampled in BIAS; out/outvalid one-cycle result pulse, out holds between pulses.
// Option: define RELU_EN to clamp negative results to zero at the output.
module neuron_mac #(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [dataWidth-1:0]    myinput,
    input  logic                    myinputValid,
    output logic                    myinputReady,
    output logic                    weight_ren,
    output logic [addressWidth:0]   weight_radd,
    input  logic [dataWidth-1:0]    weight_rdata,
    input  logic [dataWidth-1:0]    bias,
    output logic [dataWidth-1:0]    out,
    output logic                    outvalid
);
    localparam int M = dataWidth - 1;
    localparam logic [dataWidth-1:0] max_v = {1'b0, {M{1'b1}}};
    localparam logic [dataWidth-1:0] min_v = {1'b1, {M{1'b0}}};
    localparam logic [addressWidth:0] nw = (addressWidth+1)'(numWeight);
    typedef enum logic [1:0] {ACC, DRAIN, BIAS, OUT} state_t;
    state_t state;
    logic [addressWidth:0] cnt;
    logic [dataWidth-1:0] in0, in1, w1, prod, acc, prod_sat, act;
    logic v0, v1, v2, accept;
    logic signed [2*dataWidth-1:0] full, shifted;

    function automatic logic [dataWidth-1:0] sat_add(input logic [dataWidth-1:0] a, input logic [dataWidth-1:0] b);
        logic [dataWidth-1:0] s;
        s = a + b;
        return (a[M] == b[M] && s[M] != a[M]) ? (a[M] ? min_v : max_v) : s;
    endfunction

    // ready is held low during the outvalid cycle so a new neuron starts the cycle after the pulse
    assign myinputReady = state == ACC && cnt < nw && !outvalid;
    assign accept       = myinputValid && myinputReady;
    assign weight_ren   = accept;
    assign weight_radd  = cnt < nw ? cnt : '0;
    assign full         = {{dataWidth{in1[M]}}, in1} * {{dataWidth{w1[M]}}, w1};
    assign shifted      = full >>> fracBits;
    // in range only when all bits above the result's sign bit equal that sign bit
    assign prod_sat     = (&shifted[2*dataWidth-1:M] || ~|shifted[2*dataWidth-1:M]) ? shifted[M:0] : (shifted[2*dataWidth-1] ? min_v : max_v);
`ifdef RELU_EN
    assign act          = acc[M] ? '0 : acc;
`else
    assign act          = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            cnt      <= '0;
            acc      <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            in0      <= '0;
            in1      <= '0;
            w1       <= '0;
            prod     <= '0;
            out      <= '0;
            outvalid <= 1'b0;
        end else begin
            v0       <= accept;
            v1       <= v0;
            v2       <= v1;
            outvalid <= 1'b0;
            if (accept) in0 <= myinput;
            if (v0) begin
                in1 <= in0;
                w1  <= weight_rdata;
            end
            if (v1) prod <= prod_sat;
            if (state == OUT) acc <= '0;
            else if (state == BIAS) acc <= sat_add(acc, bias);
            else if (v2) acc <= sat_add(acc, prod);
            case (state)
                ACC: if (accept) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == nw - 1'b1) state <= DRAIN;
                end
                // the last product lands in acc on the edge where only stage 3 is still valid
                DRAIN: if (!v0 && !v1) state <= BIAS;
                BIAS: state <= OUT;
                OUT: begin
                    out      <= act;
                    outvalid <= 1'b1;
                    cnt      <= '0;
                    state    <= ACC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed bench for neuron_mac with a cycle model of the neuron's observable behaviour.
module tb_neuron_mac;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] myinput = '0, weight_rdata = '0, bias = '0, out;
    logic myinputValid = 1'b0, myinputReady, weight_ren, outvalid;
    logic [10:0] weight_radd;
    logic [15:0] mem [4];
    int total = 0, bad = 0, ov_cnt = 0, n_acc = 0;
    logic chk_en = 1'b0;
    logic [15:0] cap_out = '0;
    int k = 0, wt = 0;
    logic m_ov = 1'b0;
    logic [15:0] m_out = '0;
    int m_acc = 0;

    neuron_mac dut (
        .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
        .myinputReady(myinputReady), .weight_ren(weight_ren), .weight_radd(weight_radd),
        .weight_rdata(weight_rdata), .bias(bias), .out(out), .outvalid(outvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (weight_ren) weight_rdata <= mem[weight_radd[1:0]];

    function automatic int sat16(input longint v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : int'(v));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a neuron's inputs are accepted while fewer than 3 are taken and no pulse is showing;
    // the result appears 5 edges after the 3rd accept as the clamped running sum plus bias.
    always @(posedge clk) begin
        longint p;
        bit take;
        int s;
        if (rst) begin
            k = 0; wt = 0; m_ov = 1'b0; m_out = '0; m_acc = 0;
        end else begin
            take = myinputValid && k < 3 && !m_ov;
            m_ov = 1'b0;
            if (wt > 0) begin
                wt--;
                if (wt == 0) begin
                    s = sat16(longint'(m_acc) + longint'($signed(bias)));
`ifdef RELU_EN
                    if (s < 0) s = 0;
`endif
                    m_out = 16'(s);
                    m_ov = 1'b1;
                    m_acc = 0;
                    k = 0;
                end
            end
            if (take) begin
                p = (longint'($signed(myinput)) * longint'($signed(mem[k]))) >>> 12;
                m_acc = sat16(longint'(m_acc) + longint'(sat16(p)));
                k++;
                n_acc++;
                if (k == 3) wt = 5;
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("ready", int'(myinputReady), int'(k < 3 && !m_ov));
        chk("ren", int'(weight_ren), int'(myinputValid && k < 3 && !m_ov));
        chk("radd", int'(weight_radd), k < 3 ? k : 0);
        chk("outvalid", int'(outvalid), int'(m_ov));
        chk("out", int'(out), int'(m_out));
        if (outvalid) begin
            ov_cnt++;
            cap_out = out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        bit ok = 1'b0;
        myinput = d;
        myinputValid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = myinputReady;
        end
        if (!ok) chk("send_timeout", 0, 1);
        step();
        myinputValid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic setup(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] b);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = '0;
        bias = b;
    endtask

    task automatic neuron(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input int gap, input string nm, input logic [15:0] exp);
        int ov0 = ov_cnt;
        send(a, gap);
        send(b, gap);
        send(c, gap);
        repeat (8) step();
        chk({nm, "_pulses"}, ov_cnt - ov0, 1);
        chk({nm, "_dut"}, int'(cap_out), int'(exp));
        chk({nm, "_model"}, int'(m_out), int'(exp));
    endtask

    initial begin
        int ov0, n0;
        setup(16'h0800, 16'h0400, 16'h2000, 16'h0800);
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_out", int'(out), 0);
        chk("rst_ov", int'(outvalid), 0);
        chk("rst_ready", int'(myinputReady), 1);
        chk("rst_radd", int'(weight_radd), 0);
        neuron(16'h1000, 16'h2000, 16'h0800, 0, "t1", 16'h2800);
        neuron(16'h1000, 16'h2000, 16'h0800, 1, "t2", 16'h2800);
        setup(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        neuron(16'h7000, 16'h7000, 16'h7000, 0, "t3_pos", 16'h7FFF);
        setup(16'h7000, 16'h7000, 16'h7000, 16'h9000);
`ifdef RELU_EN
        neuron(16'h9000, 16'h9000, 16'h9000, 0, "t3_neg", 16'h0000);
`else
        neuron(16'h9000, 16'h9000, 16'h9000, 0, "t3_neg", 16'h8000);
`endif
        setup(16'h1000, 16'h1000, 16'h1000, 16'h0000);
        ov0 = ov_cnt;
        n0 = n_acc;
        myinput = 16'h1000;
        myinputValid = 1'b1;
        for (int t = 0; t < 100 && n_acc < n0 + 7; t++) step();
        myinputValid = 1'b0;
        chk("t4_accepted", n_acc - n0, 7);
        repeat (10) step();
        chk("t4_pulses", ov_cnt - ov0, 2);
        chk("t4_out", int'(cap_out), 16'h3000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        setup(16'h2000, 16'h2000, 16'h2000, 16'h0400);
        ov0 = ov_cnt;
        send(16'h1000, 0);
        send(16'h1000, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("t5_aborted", ov_cnt - ov0, 0);
        chk("t5_rst_out", int'(out), 0);
        setup(16'h1000, 16'h1000, 16'h1000, 16'h0000);
        neuron(16'h1000, 16'h1000, 16'h1000, 0, "t5", 16'h3000);
        setup(16'h1000, 16'h1000, 16'h1000, 16'hF000);
`ifdef RELU_EN
        neuron(16'h0800, 16'h0000, 16'h0000, 2, "t6", 16'h0000);
`else
        neuron(16'h0800, 16'h0000, 16'h0000, 2, "t6", 16'hF800);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Single-neuron multiply-accumulate stage directly downstream of the per-neuron weight memory.
- Accepts a serial stream of layer inputs and drives the memory's read port (read enable, read address) one weight per input.
- Multiplies each input by its weight in signed fixed point, accumulates with saturation, then adds the neuron bias.
- Emits one output value per numWeight inputs to the activation/next-layer stage.

Parameters:
- numWeight, 3, inputs (and weights) per neuron; count per output.
- addressWidth, 10, weight-memory address width; read address is addressWidth+1 bits.
- dataWidth, 16, signed two's-complement width of inputs, weights, bias and output.
- fracBits, 12, fractional bits of the fixed-point format (default Q4.12).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- myinput  input  dataWidth  signed input sample.
- myinputValid  input  1  sample valid.
- myinputReady  output  1  block can accept a sample this cycle.
- weight_ren  output  1  read enable to weight memory.
- weight_radd  output  addressWidth+1  read address to weight memory.
- weight_rdata  input  dataWidth  weight returned one cycle after weight_ren.
- bias  input  dataWidth  signed bias; sampled in BIAS state.
- out  output  dataWidth  signed neuron result.
- outvalid  output  1  one-cycle pulse; out valid.

Behaviour:
- Reset (rst=1 at a clock edge): state=ACC, input counter=0, accumulator=0, all pipeline valids=0, out=0, outvalid=0, weight_radd=0. Reset mid-neuron discards partial sums; no outvalid is produced for the aborted neuron.
- Accept = myinputValid & myinputReady. myinputReady=1 only in ACC while counter<numWeight.
- weight_ren = accept (combinational); weight_radd = counter (combinational), so address k is read for the k-th input (0-based).
- Stage 1 (T+1 after accept at T): register input alongside weight_rdata.
- Stage 2 (T+2): product = input*weight at full 2*dataWidth, arithmetic shift right by fracBits, clamp to [-2^(dataWidth-1), 2^(dataWidth-1)-1]; register.
- Stage 3 (T+3): acc = sat_add(acc, product). sat_add: if operands share sign and result sign differs, clamp to max positive / min negative.
- The counter increments on each accept. When the numWeight-th input is accepted, the counter equals numWeight, ready drops, and the FSM moves to DRAIN.
- FSM states:
  - ACC: accepting inputs.
  - DRAIN: wait until pipeline empty (last product accumulated, T+3).
  - BIAS: acc = sat_add(acc, bias) at T+4.
  - OUT: out <= activated acc, outvalid=1 for exactly one cycle at T+5; acc and counter cleared; return to ACC.
- myinputReady returns high the cycle after the outvalid pulse.
- Gaps in myinputValid are allowed; the pipeline advances only on accepted samples, and stage valids track each sample.
- Inputs offered while ready=0 are not consumed; weight_ren stays 0.
- weight_radd never exceeds numWeight-1.
- out holds its value between pulses.

Optional Feature:
- Macro RELU_EN.
- Defined: the OUT stage applies ReLU, so a negative biased sum gives out=0 and a non-negative sum passes unchanged.
- Undefined: out = biased saturated sum, including negatives (external activation follows).

Test Plan:
1. numWeight=3, Q4.12, weights {0x0800,0x0400,0x2000}, inputs {0x1000,0x2000,0x0800} back-to-back, bias 0x0800 -> single outvalid pulse 5 cycles after the third accept, out=0x2800; weight_radd sequence 0,1,2.
2. Same data with one idle cycle between each input -> same out=0x2800; ren asserted only on accept cycles; outvalid 5 cycles after the last accept.
3. Inputs and weights all 0x7000, bias 0x7000:
   - products saturate to 0x7FFF each;
   - acc holds 0x7FFF;
   - out=0x7FFF.
   - Repeat with inputs 0x9000 (negative) and weights 0x7000 -> out=0x8000 without RELU_EN, 0x0000 with RELU_EN.
4. Hold myinputValid=1 continuously for 7 samples -> exactly 3 accepted per neuron; ready low during DRAIN/BIAS/OUT; two outvalid pulses for the first 6 samples, the 7th pending; no ren while ready=0.
5. Assert rst for one cycle after the 2nd input of a neuron:
   - no outvalid for that neuron;
   - the next 3 inputs {0x1000,0x1000,0x1000}, weights {0x1000 x3}, bias 0 -> out=0x3000.
6. Bias 0xF000 (-1.0), products summing to 0x0800 -> out=0xF800 without RELU_EN, 0x0000 with RELU_EN.
